// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the staged reset sequencer: FSM state encoding,
// default timing constants and the counter-width helper.
package rst_seq_pkg;

    // Sequencer phases: waiting on the synchroniser, releasing stages,
    // holding after a soft reset, and fully released.
    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_HOLD    = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_t;

    localparam int DEFAULT_NUM_STAGES  = 3;
    localparam int DEFAULT_STAGE_GAP   = 10;
    localparam int DEFAULT_DONE_GAP    = 11;
    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_HOLD_CYCLES = 4;

    // Counter value at which complete rises, measured from the first release.
    function automatic int calc_done_at(input int num_stages,
                                        input int stage_gap,
                                        input int done_gap);
        return (num_stages - 1) * stage_gap + done_gap;
    endfunction

    // Width of the release counter; it must be able to hold the done value.
    function automatic int calc_cnt_w(input int num_stages,
                                      input int stage_gap,
                                      input int done_gap);
        int w;
        w = $clog2(calc_done_at(num_stages, stage_gap, done_gap) + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Bundle of the sequencer's status outputs and the soft-reset handshake.
// The sequencer drives through the master modport; consumers of the staged
// resets and the soft-reset requester sit on the slave side.
interface reset_sequencer_if
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_NUM_STAGES
) ();

    logic                  soft_rst_req;
    logic [NUM_STAGES-1:0] rst_out;
    logic                  complete;
    logic                  busy;
    logic                  soft_rst_ack;

    modport master (
        input  soft_rst_req,
        output rst_out,
        output complete,
        output busy,
        output soft_rst_ack
    );

    modport slave (
        output soft_rst_req,
        input  rst_out,
        input  complete,
        input  busy,
        input  soft_rst_ack
    );

endinterface

// File: rtl/reset_sequencer_sync.sv
// Reset synchroniser: asserts immediately with the external reset and
// deasserts only after SYNC_STAGES clean clock edges, so downstream logic
// never sees a reset release close to a clock edge.
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_async,
    output logic rst_sync
);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("reset_sync: SYNC_STAGES must be >= 2");
    end

    logic [SYNC_STAGES-1:0] chain;

    // Fill the chain with ones on reset, then shift zeros in toward the output.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            chain <= '1;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b0};
        end
    end

    assign rst_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator for the inference datapath. After the external
// reset has been synchronised, reset domains are released one by one at a
// fixed spacing, then complete is raised. A soft-reset request re-runs the
// sequence without a board-level reset.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = DEFAULT_NUM_STAGES,
    parameter int STAGE_GAP   = DEFAULT_STAGE_GAP,
    parameter int DONE_GAP    = DEFAULT_DONE_GAP,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic                 clk,
    input  logic                 ext_reset,
    reset_sequencer_if.master    bus
);

    if (NUM_STAGES < 1) begin : g_bad_num_stages
        $error("reset_sequencer: NUM_STAGES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_bad_stage_gap
        $error("reset_sequencer: STAGE_GAP must be >= 1");
    end
    if (DONE_GAP < 1) begin : g_bad_done_gap
        $error("reset_sequencer: DONE_GAP must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
        $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end

    localparam int DONE_AT = calc_done_at(NUM_STAGES, STAGE_GAP, DONE_GAP);
    localparam int CNT_W   = calc_cnt_w(NUM_STAGES, STAGE_GAP, DONE_GAP);
    localparam int HOLD_W  = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  DONE_AT_C = CNT_W'(DONE_AT);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    seq_state_t            state;
    seq_state_t            state_next;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [HOLD_W-1:0]     hold_cnt_next;
    logic                  accept;
    logic                  released_next;
    logic                  sync_rst;

    logic [NUM_STAGES-1:0] rst_out_q;
    logic [NUM_STAGES-1:0] rst_out_next;
    logic                  complete_q;
    logic                  busy_q;
    logic                  ack_q;

    reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk       (clk),
        .rst_async (ext_reset),
        .rst_sync  (sync_rst)
    );

    // Next-state, counter and registered-output values for the coming edge.
    // A soft reset wins over everything but ext_reset, including the edge
    // where complete would otherwise rise.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        hold_cnt_next = hold_cnt;
        accept        = 1'b0;
        released_next = 1'b0;
        rst_out_next  = '1;

        unique case (state)
            ST_SYNC: begin
                if (!sync_rst) begin
                    state_next = ST_RELEASE;
                    cnt_next   = '0;
                end
            end
            ST_RELEASE: begin
                if (bus.soft_rst_req) begin
                    accept = 1'b1;
                end else begin
                    if (cnt != DONE_AT_C) begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                    if (cnt_next == DONE_AT_C) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.soft_rst_req) begin
                    accept = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next    = ST_RELEASE;
                    cnt_next      = '0;
                    hold_cnt_next = '0;
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                state_next = ST_SYNC;
                cnt_next   = '0;
            end
        endcase

        if (accept) begin
            state_next    = ST_HOLD;
            cnt_next      = '0;
            hold_cnt_next = '0;
        end

        released_next = (state_next == ST_RELEASE) || (state_next == ST_DONE);
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (released_next && (int'(cnt_next) >= k * STAGE_GAP)) begin
                rst_out_next[k] = 1'b0;
            end
        end
    end

    // State, counters and all outputs are registered; ext_reset forces the
    // fully-asserted condition without waiting for a clock edge.
    always_ff @(posedge clk or posedge ext_reset) begin
        if (ext_reset) begin
            state      <= ST_SYNC;
            cnt        <= '0;
            hold_cnt   <= '0;
            rst_out_q  <= '1;
            complete_q <= 1'b0;
            busy_q     <= 1'b1;
            ack_q      <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            hold_cnt   <= hold_cnt_next;
            rst_out_q  <= rst_out_next;
            complete_q <= (state_next == ST_DONE);
            busy_q     <= (state_next != ST_DONE);
            ack_q      <= accept;
        end
    end

    assign bus.rst_out      = rst_out_q;
    assign bus.complete     = complete_q;
    assign bus.busy         = busy_q;
    assign bus.soft_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three differently parameterised instances share
// one clock and ext_reset. A timeline model (release instant T0 per instance,
// last accepted soft reset) predicts every output on every falling edge, and
// directed steps pin that model with hand-computed literals.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic ext_reset = 1'b0;
    logic req [3];

    int cyc = 0;
    int tests = 0;
    int failures = 0;
    bit check_en = 1'b0;

    int ns_p [3] = '{3, 1, 5};
    int sg_p [3] = '{10, 1, 1};
    int dg_p [3] = '{11, 1, 1};
    int ss_p [3] = '{2, 3, 3};
    int hc_p [3] = '{4, 2, 1};

    int t0 [3];
    bit t0_valid [3];
    int ack_cyc [3];

    logic [7:0] act_rst [3];
    logic [7:0] act_cmp [3];
    logic [7:0] act_busy [3];
    logic [7:0] act_ack [3];

    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_STAGES(3)) bus_a ();
    reset_sequencer_if #(.NUM_STAGES(1)) bus_b ();
    reset_sequencer_if #(.NUM_STAGES(5)) bus_c ();

    reset_sequencer #(
        .NUM_STAGES(3), .STAGE_GAP(10), .DONE_GAP(11), .SYNC_STAGES(2), .HOLD_CYCLES(4)
    ) dut_a (.clk(clk), .ext_reset(ext_reset), .bus(bus_a));

    reset_sequencer #(
        .NUM_STAGES(1), .STAGE_GAP(1), .DONE_GAP(1), .SYNC_STAGES(3), .HOLD_CYCLES(2)
    ) dut_b (.clk(clk), .ext_reset(ext_reset), .bus(bus_b));

    reset_sequencer #(
        .NUM_STAGES(5), .STAGE_GAP(1), .DONE_GAP(1), .SYNC_STAGES(3), .HOLD_CYCLES(1)
    ) dut_c (.clk(clk), .ext_reset(ext_reset), .bus(bus_c));

    assign bus_a.soft_rst_req = req[0];
    assign bus_b.soft_rst_req = req[1];
    assign bus_c.soft_rst_req = req[2];

    assign act_rst[0]  = {5'b0, bus_a.rst_out};
    assign act_rst[1]  = {7'b0, bus_b.rst_out};
    assign act_rst[2]  = {3'b0, bus_c.rst_out};
    assign act_cmp[0]  = {7'b0, bus_a.complete};
    assign act_cmp[1]  = {7'b0, bus_b.complete};
    assign act_cmp[2]  = {7'b0, bus_c.complete};
    assign act_busy[0] = {7'b0, bus_a.busy};
    assign act_busy[1] = {7'b0, bus_b.busy};
    assign act_busy[2] = {7'b0, bus_c.busy};
    assign act_ack[0]  = {7'b0, bus_a.soft_rst_ack};
    assign act_ack[1]  = {7'b0, bus_b.soft_rst_ack};
    assign act_ack[2]  = {7'b0, bus_c.soft_rst_ack};

    // Timeline model: T0 is the edge where stage 0 releases; every other
    // output is a fixed offset from it. Accepted soft resets move T0.
    always @(posedge clk) begin : model_p
        int c;
        c = cyc + 1;
        cyc <= c;
        for (int d = 0; d < 3; d++) begin
            if (ext_reset) begin
                t0_valid[d] <= 1'b0;
                ack_cyc[d]  <= -1;
            end else if (!t0_valid[d]) begin
                t0[d]       <= c + ss_p[d];
                t0_valid[d] <= 1'b1;
            end else if (req[d] && c > t0[d]) begin
                ack_cyc[d] <= c;
                t0[d]      <= c + hc_p[d];
            end
        end
    end

    task automatic checkOutput(input string name, input int d,
                               input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %0h, expected %0h",
                     name, d, cyc, act, exp);
        end
    endtask

    // Every falling edge: compare all outputs of every instance with the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int d = 0; d < 3; d++) begin
                logic [7:0] er;
                logic [7:0] ec;
                logic [7:0] eb;
                logic [7:0] ea;
                int e;
                er = 8'h00;
                if (ext_reset || !t0_valid[d] || cyc < t0[d]) begin
                    for (int k = 0; k < ns_p[d]; k++) er[k] = 1'b1;
                    ec = 8'h00;
                    eb = 8'h01;
                end else begin
                    e = cyc - t0[d];
                    for (int k = 0; k < ns_p[d]; k++) er[k] = (e < k * sg_p[d]);
                    ec = (e >= (ns_p[d] - 1) * sg_p[d] + dg_p[d]) ? 8'h01 : 8'h00;
                    eb = (ec == 8'h01) ? 8'h00 : 8'h01;
                end
                ea = (!ext_reset && ack_cyc[d] == cyc) ? 8'h01 : 8'h00;
                checkOutput("model_rst_out", d, act_rst[d], er);
                checkOutput("model_complete", d, act_cmp[d], ec);
                checkOutput("model_busy", d, act_busy[d], eb);
                checkOutput("model_ack", d, act_ack[d], ea);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] r);
        req[0] = r[0];
        req[1] = r[1];
        req[2] = r[2];
    endtask

    task automatic assertResetAsync();
        #2 ext_reset = 1'b1;
    endtask

    task automatic gotoEdge(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != target) begin
            tests++;
            failures++;
            $display("[TB] FAIL gotoEdge: at cycle %0d, required cycle %0d", cyc, target);
        end
    endtask

    initial begin : watchdog
        #2000000;
        tests++;
        failures++;
        $display("[TB] FAIL watchdog: stuck at cycle %0d, required end of run", cyc);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

    initial begin : stim
        int e0, e1, e2, s, s2, s3, fin, hold;
        applyStimulus(3'b000);
        for (int d = 0; d < 3; d++) begin
            t0_valid[d] = 1'b0;
            ack_cyc[d]  = -1;
            t0[d]       = 0;
        end
        #2 ext_reset = 1'b1;
        check_en = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset_rst_out", 0, act_rst[0], 8'h07);
        checkOutput("reset_complete", 0, act_cmp[0], 8'h00);
        checkOutput("reset_busy", 0, act_busy[0], 8'h01);
        checkOutput("reset_ack", 0, act_ack[0], 8'h00);

        // Power-up release with literal edge expectations
        e0 = cyc;
        ext_reset = 1'b0;
        gotoEdge(e0 + 2);  checkOutput("pu_e2", 0, act_rst[0], 8'h07);
        gotoEdge(e0 + 3);  checkOutput("pu_e3", 0, act_rst[0], 8'h06);
                           checkOutput("pu_b_e3", 1, act_rst[1], 8'h01);
                           checkOutput("pu_c_e3", 2, act_rst[2], 8'h1F);
        gotoEdge(e0 + 4);  checkOutput("pu_b_e4", 1, act_rst[1], 8'h00);
                           checkOutput("pu_c_e4", 2, act_rst[2], 8'h1E);
                           checkOutput("pu_b_cmp_e4", 1, act_cmp[1], 8'h00);
        gotoEdge(e0 + 5);  checkOutput("pu_b_cmp_e5", 1, act_cmp[1], 8'h01);
        gotoEdge(e0 + 8);  checkOutput("pu_c_e8", 2, act_rst[2], 8'h00);
                           checkOutput("pu_c_cmp_e8", 2, act_cmp[2], 8'h00);
        gotoEdge(e0 + 9);  checkOutput("pu_c_cmp_e9", 2, act_cmp[2], 8'h01);
        gotoEdge(e0 + 12); checkOutput("pu_e12", 0, act_rst[0], 8'h06);
        gotoEdge(e0 + 13); checkOutput("pu_e13", 0, act_rst[0], 8'h04);
        gotoEdge(e0 + 22); checkOutput("pu_e22", 0, act_rst[0], 8'h04);
        gotoEdge(e0 + 23); checkOutput("pu_e23", 0, act_rst[0], 8'h00);
        gotoEdge(e0 + 33); checkOutput("pu_cmp_e33", 0, act_cmp[0], 8'h00);
                           checkOutput("pu_busy_e33", 0, act_busy[0], 8'h01);
        gotoEdge(e0 + 34); checkOutput("pu_cmp_e34", 0, act_cmp[0], 8'h01);
                           checkOutput("pu_busy_e34", 0, act_busy[0], 8'h00);

        // Soft reset from DONE, single-cycle request
        gotoEdge(e0 + 40);
        applyStimulus(3'b001);
        s = cyc + 1;
        gotoEdge(s);
        applyStimulus(3'b000);
        checkOutput("sr_ack", 0, act_ack[0], 8'h01);
        checkOutput("sr_rst", 0, act_rst[0], 8'h07);
        checkOutput("sr_cmp", 0, act_cmp[0], 8'h00);
        gotoEdge(s + 1);  checkOutput("sr_ack_s1", 0, act_ack[0], 8'h00);
        gotoEdge(s + 3);  checkOutput("sr_s3", 0, act_rst[0], 8'h07);
        gotoEdge(s + 4);  checkOutput("sr_s4", 0, act_rst[0], 8'h06);
        gotoEdge(s + 14); checkOutput("sr_s14", 0, act_rst[0], 8'h04);
        gotoEdge(s + 24); checkOutput("sr_s24", 0, act_rst[0], 8'h00);
        gotoEdge(s + 34); checkOutput("sr_cmp_s34", 0, act_cmp[0], 8'h00);
        gotoEdge(s + 35); checkOutput("sr_cmp_s35", 0, act_cmp[0], 8'h01);

        // Request held through HOLD is ignored there
        gotoEdge(s + 40);
        applyStimulus(3'b001);
        s2 = cyc + 1;
        gotoEdge(s2);     checkOutput("hold_ack_s", 0, act_ack[0], 8'h01);
        gotoEdge(s2 + 4); checkOutput("hold_ack_s4", 0, act_ack[0], 8'h00);
                          checkOutput("hold_rst_s4", 0, act_rst[0], 8'h06);
        applyStimulus(3'b000);
        gotoEdge(s2 + 5); checkOutput("hold_rst_s5", 0, act_rst[0], 8'h06);
        gotoEdge(s2 + 39); checkOutput("hold_cmp_s39", 0, act_cmp[0], 8'h01);

        // Request held in RELEASE restarts the sequence on every acceptance
        gotoEdge(s2 + 45);
        applyStimulus(3'b001);
        s3 = cyc + 1;
        gotoEdge(s3 + 5);  checkOutput("rel_ack_s5", 0, act_ack[0], 8'h01);
        gotoEdge(s3 + 6);  checkOutput("rel_ack_s6", 0, act_ack[0], 8'h00);
        gotoEdge(s3 + 9);  checkOutput("rel_rst_s9", 0, act_rst[0], 8'h06);
        gotoEdge(s3 + 10); checkOutput("rel_rst_s10", 0, act_rst[0], 8'h07);
                           checkOutput("rel_ack_s10", 0, act_ack[0], 8'h01);
        applyStimulus(3'b000);

        // Collision with the complete edge: soft reset wins
        gotoEdge(s3 + 44);
        applyStimulus(3'b001);
        gotoEdge(s3 + 45);
        applyStimulus(3'b000);
        checkOutput("col_cmp", 0, act_cmp[0], 8'h00);
        checkOutput("col_ack", 0, act_ack[0], 8'h01);
        checkOutput("col_busy", 0, act_busy[0], 8'h01);
        gotoEdge(s3 + 79); checkOutput("col_cmp_79", 0, act_cmp[0], 8'h00);
        gotoEdge(s3 + 80); checkOutput("col_cmp_80", 0, act_cmp[0], 8'h01);

        // Asynchronous ext_reset from DONE, then requests during SYNC
        gotoEdge(s3 + 85);
        assertResetAsync();
        #1;
        checkOutput("async_rst", 0, act_rst[0], 8'h07);
        checkOutput("async_cmp", 0, act_cmp[0], 8'h00);
        checkOutput("async_busy", 0, act_busy[0], 8'h01);
        repeat (3) @(negedge clk);
        applyStimulus(3'b111);
        ext_reset = 1'b0;
        e1 = cyc;
        gotoEdge(e1 + 2);
        applyStimulus(3'b000);
        gotoEdge(e1 + 3); checkOutput("sync_rst_e3", 0, act_rst[0], 8'h06);
                          checkOutput("sync_ack_e3", 0, act_ack[0], 8'h00);
        gotoEdge(e1 + 4); checkOutput("sync_b_e4", 1, act_rst[1], 8'h00);

        // Mid-sequence ext_reset between edges, then identical re-run
        gotoEdge(e1 + 15);
        checkOutput("mid_pre", 0, act_rst[0], 8'h04);
        assertResetAsync();
        #1;
        checkOutput("mid_rst", 0, act_rst[0], 8'h07);
        checkOutput("mid_cmp", 0, act_cmp[0], 8'h00);
        repeat (2) @(negedge clk);
        ext_reset = 1'b0;
        e2 = cyc;
        gotoEdge(e2 + 3);  checkOutput("mid_e3", 0, act_rst[0], 8'h06);
        gotoEdge(e2 + 13); checkOutput("mid_e13", 0, act_rst[0], 8'h04);
        gotoEdge(e2 + 23); checkOutput("mid_e23", 0, act_rst[0], 8'h00);
        gotoEdge(e2 + 34); checkOutput("mid_cmp_e34", 0, act_cmp[0], 8'h01);

        // Randomised requests and occasional asynchronous resets
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) req[d] = ($urandom_range(0, 11) == 0);
            if (ext_reset) begin
                if (hold == 0) ext_reset = 1'b0;
                else hold--;
            end else if ($urandom_range(0, 199) == 0) begin
                hold = $urandom_range(1, 3);
                assertResetAsync();
            end
        end

        // Quiet tail: everything must settle to complete
        @(negedge clk);
        applyStimulus(3'b000);
        ext_reset = 1'b0;
        fin = cyc;
        gotoEdge(fin + 60);
        for (int d = 0; d < 3; d++) begin
            checkOutput("final_cmp", d, act_cmp[d], 8'h01);
            checkOutput("final_busy", d, act_busy[d], 8'h00);
            checkOutput("final_rst", d, act_rst[d], 8'h00);
        end

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
